// File: rtl/uart_hid_receiver.sv
// UART 8N1 receiver that decodes framed HID reports (A5, TYPE, payload, CHK)
// into the same keyboard/mouse/gamepad outputs the USB HID host core drives.
module uart_hid_receiver #(
    parameter int CLK_FREQ     = 12000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              uart_rx,
    output logic [1:0]        typ,
    output logic              report,
    output logic              frame_err,
    output logic [7:0]        key_modifiers,
    output logic [7:0]        key1,
    output logic [7:0]        key2,
    output logic [7:0]        key3,
    output logic [7:0]        key4,
    output logic [7:0]        mouse_btn,
    output logic signed [7:0] mouse_dx,
    output logic signed [7:0] mouse_dy,
    output logic              game_l,
    output logic              game_r,
    output logic              game_u,
    output logic              game_d,
    output logic              game_a,
    output logic              game_b,
    output logic              game_x,
    output logic              game_y,
    output logic              game_sel,
    output logic              game_sta
);

    localparam int DIV       = CLK_FREQ / BAUD;
    localparam int HALF      = DIV / 2;
    localparam int CW        = $clog2(DIV + 1);
    localparam int TO_CYCLES = TIMEOUT_BITS * DIV;
    localparam int TW        = $clog2(TO_CYCLES + 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rxState_e;
    typedef enum logic [1:0] {F_SYNC, F_TYPE, F_PAYLOAD, F_CHECK} frState_e;

    logic           rxMeta_q, rxSync_q, rxPrev_q;
    rxState_e       rxState_q;
    logic [CW-1:0]  baudCnt_q;
    logic [2:0]     bitIdx_q;
    logic [7:0]     shift_q;
    logic           byteValid_q;
    logic           rxErr_q;

    frState_e       frState_q;
    logic [1:0]     frType_q;
    logic [2:0]     payCnt_q;
    logic [2:0]     payLast_q;
    logic [7:0]     chk_q;
    logic [7:0]     shadow_q [0:4];
    logic [TW-1:0]  idleCnt_q;

    // Synchronizer plus one extra flop for falling-edge detection.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= uart_rx;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rxState_q   <= RX_IDLE;
            baudCnt_q   <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            byteValid_q <= 1'b0;
            rxErr_q     <= 1'b0;
        end else begin
            byteValid_q <= 1'b0;
            rxErr_q     <= 1'b0;
            case (rxState_q)
                RX_IDLE: begin
                    baudCnt_q <= '0;
                    bitIdx_q  <= '0;
                    if (rxPrev_q && !rxSync_q)
                        rxState_q <= RX_START;
                end
                RX_START: begin
                    if (baudCnt_q == CW'(HALF - 1)) begin
                        baudCnt_q <= '0;
                        rxState_q <= rxSync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (baudCnt_q == CW'(DIV - 1)) begin
                        baudCnt_q <= '0;
                        shift_q   <= {rxSync_q, shift_q[7:1]};
                        bitIdx_q  <= bitIdx_q + 1'b1;
                        if (bitIdx_q == 3'd7)
                            rxState_q <= RX_STOP;
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (baudCnt_q == CW'(DIV - 1)) begin
                        baudCnt_q <= '0;
                        if (rxSync_q) begin
                            byteValid_q <= 1'b1;
                            rxState_q   <= RX_IDLE;
                        end else begin
                            rxErr_q   <= 1'b1;
                            rxState_q <= RX_WAIT;
                        end
                    end else begin
                        baudCnt_q <= baudCnt_q + 1'b1;
                    end
                end
                RX_WAIT: begin
                    // A low stop bit may be a break; wait for idle before hunting again.
                    if (rxSync_q)
                        rxState_q <= RX_IDLE;
                end
                default: rxState_q <= RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            frState_q     <= F_SYNC;
            frType_q      <= '0;
            payCnt_q      <= '0;
            payLast_q     <= '0;
            chk_q         <= '0;
            idleCnt_q     <= '0;
            for (int i = 0; i < 5; i++) shadow_q[i] <= '0;
            typ           <= '0;
            report        <= 1'b0;
            frame_err     <= 1'b0;
            key_modifiers <= '0;
            key1          <= '0;
            key2          <= '0;
            key3          <= '0;
            key4          <= '0;
            mouse_btn     <= '0;
            mouse_dx      <= '0;
            mouse_dy      <= '0;
            {game_y, game_x, game_b, game_a, game_d, game_u, game_r, game_l} <= '0;
            game_sel      <= 1'b0;
            game_sta      <= 1'b0;
        end else begin
            report    <= 1'b0;
            frame_err <= 1'b0;
            if (rxErr_q) begin
                frame_err <= 1'b1;
                frState_q <= F_SYNC;
                idleCnt_q <= '0;
            end else if (byteValid_q) begin
                idleCnt_q <= '0;
                case (frState_q)
                    F_SYNC: begin
                        if (shift_q == 8'hA5)
                            frState_q <= F_TYPE;
                    end
                    F_TYPE: begin
                        if (shift_q >= 8'd1 && shift_q <= 8'd3) begin
                            frType_q  <= shift_q[1:0];
                            chk_q     <= shift_q;
                            payCnt_q  <= '0;
                            payLast_q <= (shift_q[1:0] == 2'd1) ? 3'd4 :
                                         (shift_q[1:0] == 2'd2) ? 3'd2 : 3'd1;
                            frState_q <= F_PAYLOAD;
                        end else begin
                            frame_err <= 1'b1;
                            frState_q <= F_SYNC;
                        end
                    end
                    F_PAYLOAD: begin
                        shadow_q[payCnt_q] <= shift_q;
                        chk_q              <= chk_q ^ shift_q;
                        payCnt_q           <= payCnt_q + 1'b1;
                        if (payCnt_q == payLast_q)
                            frState_q <= F_CHECK;
                    end
                    F_CHECK: begin
                        frState_q <= F_SYNC;
                        if (shift_q == chk_q) begin
                            report <= 1'b1;
                            typ    <= frType_q;
                            case (frType_q)
                                2'd1: begin
                                    key_modifiers <= shadow_q[0];
                                    key1          <= shadow_q[1];
                                    key2          <= shadow_q[2];
                                    key3          <= shadow_q[3];
                                    key4          <= shadow_q[4];
                                end
                                2'd2: begin
                                    mouse_btn <= shadow_q[0];
                                    mouse_dx  <= shadow_q[1];
                                    mouse_dy  <= shadow_q[2];
                                end
                                2'd3: begin
                                    {game_y, game_x, game_b, game_a,
                                     game_d, game_u, game_r, game_l} <= shadow_q[0];
                                    game_sel <= shadow_q[1][0];
                                    game_sta <= shadow_q[1][1];
                                end
                                default: ;
                            endcase
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: frState_q <= F_SYNC;
                endcase
            end else if (frState_q != F_SYNC) begin
                // Any activity on the receiver counts as a start arriving in time.
                if (rxState_q != RX_IDLE) begin
                    idleCnt_q <= '0;
                end else if (idleCnt_q == TW'(TO_CYCLES - 1)) begin
                    frame_err <= 1'b1;
                    frState_q <= F_SYNC;
                    idleCnt_q <= '0;
                end else begin
                    idleCnt_q <= idleCnt_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_hid_receiver.sv
// Self-checking bench for uart_hid_receiver: table of whole frames plus
// hand-written sequences for timeout, framing error, glitch and mid-frame reset.
module tb_uart_hid_receiver;

    localparam int CLK_FREQ     = 1152000;
    localparam int BAUD         = 115200;
    localparam int TIMEOUT_BITS = 20;
    localparam int DIV          = CLK_FREQ / BAUD;

    logic              clk;
    logic              resetn;
    logic              uart_rx;
    logic [1:0]        typ;
    logic              report;
    logic              frame_err;
    logic [7:0]        key_modifiers, key1, key2, key3, key4;
    logic [7:0]        mouse_btn;
    logic signed [7:0] mouse_dx, mouse_dy;
    logic              game_l, game_r, game_u, game_d, game_a, game_b;
    logic              game_x, game_y, game_sel, game_sta;

    int checks;
    int errors;
    int repCnt;
    int errCnt;
    int bothCnt;

    typedef struct {
        logic [63:0] bytes;
        int          n;
        int          expRep;
        int          expErr;
        logic [1:0]  expTyp;
        logic [39:0] expKey;
        logic [23:0] expMouse;
        logic [9:0]  expGame;
    } vec_t;

    vec_t vecs [10];

    uart_hid_receiver #(
        .CLK_FREQ    (CLK_FREQ),
        .BAUD        (BAUD),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .uart_rx      (uart_rx),
        .typ          (typ),
        .report       (report),
        .frame_err    (frame_err),
        .key_modifiers(key_modifiers),
        .key1         (key1),
        .key2         (key2),
        .key3         (key3),
        .key4         (key4),
        .mouse_btn    (mouse_btn),
        .mouse_dx     (mouse_dx),
        .mouse_dy     (mouse_dy),
        .game_l       (game_l),
        .game_r       (game_r),
        .game_u       (game_u),
        .game_d       (game_d),
        .game_a       (game_a),
        .game_b       (game_b),
        .game_x       (game_x),
        .game_y       (game_y),
        .game_sel     (game_sel),
        .game_sta     (game_sta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (report)              repCnt++;
        if (frame_err)           errCnt++;
        if (report && frame_err) bothCnt++;
    end

    function automatic logic [39:0] keyVec();
        return {key_modifiers, key1, key2, key3, key4};
    endfunction

    function automatic logic [23:0] mouseVec();
        return {mouse_btn, mouse_dx, mouse_dy};
    endfunction

    function automatic logic [9:0] gameVec();
        return {game_sta, game_sel, game_y, game_x, game_b, game_a,
                game_d, game_u, game_r, game_l};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit badStop);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = !badStop;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    // Bytes are left-aligned: byte 0 occupies bits 63:56.
    task automatic applyStimulus(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++)
            sendByte(bytes[63 - 8*i -: 8], 1'b0);
    endtask

    task automatic checkState(input string tag, input logic [1:0] eTyp, input logic [39:0] eKey,
                              input logic [23:0] eMouse, input logic [9:0] eGame);
        checkOutput({tag, " typ"},   64'(typ),        64'(eTyp));
        checkOutput({tag, " key"},   64'(keyVec()),   64'(eKey));
        checkOutput({tag, " mouse"}, 64'(mouseVec()), 64'(eMouse));
        checkOutput({tag, " game"},  64'(gameVec()),  64'(eGame));
    endtask

    task automatic checkPulses(input string tag, input int rep0, input int err0,
                               input int eRep, input int eErr);
        checkOutput({tag, " reports"}, 64'(repCnt - rep0), 64'(eRep));
        checkOutput({tag, " errs"},    64'(errCnt - err0), 64'(eErr));
    endtask

    initial begin
        int rep0, err0;
        checks  = 0;
        errors  = 0;
        repCnt  = 0;
        errCnt  = 0;
        bothCnt = 0;

        vecs[0] = '{64'hA5_01_02_04_00_00_00_07, 8, 1, 0, 2'd1, 40'h02_04_00_00_00, 24'h00_00_00, 10'h000};
        vecs[1] = '{64'hA5_02_01_FB_05_FD_00_00, 6, 1, 0, 2'd2, 40'h02_04_00_00_00, 24'h01_FB_05, 10'h000};
        vecs[2] = '{64'hA5_03_11_02_10_00_00_00, 5, 1, 0, 2'd3, 40'h02_04_00_00_00, 24'h01_FB_05, 10'h211};
        vecs[3] = '{64'hA5_01_09_08_07_06_05_00, 8, 0, 1, 2'd3, 40'h02_04_00_00_00, 24'h01_FB_05, 10'h211};
        vecs[4] = '{64'hA5_01_09_08_07_06_05_04, 8, 1, 0, 2'd1, 40'h09_08_07_06_05, 24'h01_FB_05, 10'h211};
        vecs[5] = '{64'hA5_04_00_00_00_00_00_00, 2, 0, 1, 2'd1, 40'h09_08_07_06_05, 24'h01_FB_05, 10'h211};
        vecs[6] = '{64'h12_FF_A5_02_80_7F_81_7C, 8, 1, 0, 2'd2, 40'h09_08_07_06_05, 24'h80_7F_81, 10'h211};
        vecs[7] = '{64'hA5_02_A5_01_02_A4_00_00, 6, 1, 0, 2'd2, 40'h09_08_07_06_05, 24'hA5_01_02, 10'h211};
        vecs[8] = '{64'hA5_03_EE_FD_10_00_00_00, 5, 1, 0, 2'd3, 40'h09_08_07_06_05, 24'hA5_01_02, 10'h1EE};
        vecs[9] = '{64'hA5_00_00_00_00_00_00_00, 2, 0, 1, 2'd3, 40'h09_08_07_06_05, 24'hA5_01_02, 10'h1EE};

        uart_rx = 1'b1;
        resetn  = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset report", 64'(report), 64'd0);
        checkOutput("reset frame_err", 64'(frame_err), 64'd0);
        checkState("reset", 2'd0, 40'h0, 24'h0, 10'h0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            rep0 = repCnt;
            err0 = errCnt;
            applyStimulus(vecs[i].bytes, vecs[i].n);
            repeat (3 * DIV) @(negedge clk);
            checkPulses($sformatf("v%0d", i), rep0, err0, vecs[i].expRep, vecs[i].expErr);
            checkState($sformatf("v%0d", i), vecs[i].expTyp, vecs[i].expKey,
                       vecs[i].expMouse, vecs[i].expGame);
        end

        // Inter-byte timeout: silent before 20 bit-times, error by 25.
        rep0 = repCnt;
        err0 = errCnt;
        applyStimulus(64'hA5_01_02_00_00_00_00_00, 3);
        repeat (18 * DIV) @(negedge clk);
        checkPulses("timeout early", rep0, err0, 0, 0);
        repeat (7 * DIV) @(negedge clk);
        checkPulses("timeout late", rep0, err0, 0, 1);
        rep0 = repCnt;
        err0 = errCnt;
        applyStimulus(64'hA5_02_01_FB_05_FD_00_00, 6);
        repeat (3 * DIV) @(negedge clk);
        checkPulses("after timeout", rep0, err0, 1, 0);
        checkState("after timeout", 2'd2, 40'h09_08_07_06_05, 24'h01_FB_05, 10'h1EE);

        // Bad stop bit on the TYPE byte aborts the frame.
        rep0 = repCnt;
        err0 = errCnt;
        sendByte(8'hA5, 1'b0);
        sendByte(8'h01, 1'b1);
        repeat (3 * DIV) @(negedge clk);
        checkPulses("stop err", rep0, err0, 0, 1);
        rep0 = repCnt;
        err0 = errCnt;
        applyStimulus(64'hA5_01_02_04_00_00_00_07, 8);
        repeat (3 * DIV) @(negedge clk);
        checkPulses("after stop err", rep0, err0, 1, 0);
        checkState("after stop err", 2'd1, 40'h02_04_00_00_00, 24'h01_FB_05, 10'h1EE);

        // One-cycle low glitch on an idle line, then inside a frame.
        rep0 = repCnt;
        err0 = errCnt;
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        checkPulses("idle glitch", rep0, err0, 0, 0);
        sendByte(8'hA5, 1'b0);
        repeat (2 * DIV) @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        applyStimulus(64'h02_03_04_05_00_00_00_00, 5);
        repeat (3 * DIV) @(negedge clk);
        checkPulses("frame glitch", rep0, err0, 1, 0);
        checkState("frame glitch", 2'd2, 40'h02_04_00_00_00, 24'h03_04_05, 10'h1EE);

        // Reset in the middle of a byte inside a frame.
        sendByte(8'hA5, 1'b0);
        sendByte(8'h01, 1'b0);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * DIV) @(negedge clk);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checkState("mid reset", 2'd0, 40'h0, 24'h0, 10'h0);
        resetn = 1'b1;
        repeat (2 * DIV) @(negedge clk);
        rep0 = repCnt;
        err0 = errCnt;
        applyStimulus(64'hA5_03_11_02_10_00_00_00, 5);
        repeat (3 * DIV) @(negedge clk);
        checkPulses("after reset", rep0, err0, 1, 0);
        checkState("after reset", 2'd3, 40'h0, 24'h0, 10'h211);

        checkOutput("report with frame_err", 64'(bothCnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
